// File: rtl/fp_to_int.sv
// Multi-cycle float (s | 10-bit exp | 21-bit mant) to signed integer converter.
// Optional round-to-nearest-even when FP2INT_ROUND_EN is defined; truncation otherwise.
module fp_to_int #(
  parameter int BIAS  = 511,
  parameter int OUT_W = 32
) (
  input  logic             clock_100Khz,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      op_in,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] data_out,
  output logic [3:0]       status_out
);

  localparam logic [3:0] ST_OVF     = 4'd0;
  localparam logic [3:0] ST_UNF     = 4'd1;
  localparam logic [3:0] ST_EXACT   = 4'd2;
  localparam logic [3:0] ST_INEXACT = 4'd3;

  localparam logic signed [10:0] L_BIAS  = 11'(BIAS);
  localparam logic signed [10:0] L_EMAX  = 11'(OUT_W - 2);
  localparam logic signed [10:0] L_ETOP  = 11'(OUT_W - 1);
  localparam logic signed [10:0] L_MBITS = 11'sd21;
`ifdef FP2INT_ROUND_EN
  localparam logic signed [10:0] L_E_LO  = -11'sd1;
`else
  localparam logic signed [10:0] L_E_LO  = 11'sd0;
`endif

  localparam logic [OUT_W:0] L_MIN_MAG = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W:0] L_MAX_MAG = {2'b00, {(OUT_W-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_SHIFT,
    S_WB
  } state_t;

  state_t           r_state;
  logic [31:0]      r_op;
  logic [OUT_W:0]   r_sh;
  logic [5:0]       r_cnt;
  logic             r_left;
  logic             r_sticky;
  logic             r_force;
  logic [3:0]       r_stat;
  logic             r_busy;
  logic             r_done;
  logic [OUT_W-1:0] r_data;
  logic [3:0]       r_status;
`ifdef FP2INT_ROUND_EN
  logic             r_guard;
`endif

  logic               w_sign;
  logic [9:0]         w_exp;
  logic [20:0]        w_mant;
  logic [21:0]        w_mag;
  logic signed [10:0] w_e;
  logic signed [10:0] w_dist;
  logic [10:0]        w_n;
  logic               w_zero;
  logic               w_unf;
  logic               w_small;
  logic               w_ovf;
  logic               w_ovf_exact;
  logic [OUT_W-1:0]   w_mag_out;
  logic [OUT_W-1:0]   w_res;
  logic               w_inexact;
  logic               w_unused;

  assign w_sign      = r_op[31];
  assign w_exp       = r_op[30:21];
  assign w_mant      = r_op[20:0];
  assign w_mag       = {1'b1, w_mant};
  assign w_e         = $signed({1'b0, w_exp}) - L_BIAS;
  assign w_dist      = w_e - L_MBITS;
  assign w_n         = (w_dist < 11'sd0) ? 11'(-w_dist) : 11'(w_dist);
  assign w_zero      = (w_exp == '0) && (w_mant == '0);
  assign w_unf       = (w_exp == '0) && (w_mant != '0);
  assign w_small     = (w_e < L_E_LO);
  assign w_ovf       = (w_e > L_EMAX);
  assign w_ovf_exact = w_sign && (w_e == L_ETOP) && (w_mant == '0);

  // Guard is the last bit shifted out; sticky holds everything below it.
`ifdef FP2INT_ROUND_EN
  logic w_round_up;
  assign w_round_up = r_guard & (r_sticky | r_sh[0]);
  assign w_mag_out  = r_sh[OUT_W-1:0] + {{(OUT_W-1){1'b0}}, w_round_up};
  assign w_inexact  = r_guard | r_sticky;
`else
  assign w_mag_out  = r_sh[OUT_W-1:0];
  assign w_inexact  = r_sticky;
`endif

  // Magnitude of -2^(OUT_W-1) negates onto itself, so the overflow cases share this path.
  assign w_res    = w_sign ? -w_mag_out : w_mag_out;
  assign w_unused = ^{r_sh[OUT_W], w_n[10:6]};

  always_ff @(posedge clock_100Khz or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_left   <= 1'b0;
      r_sticky <= 1'b0;
      r_force  <= 1'b0;
      r_stat   <= ST_EXACT;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_data   <= '0;
      r_status <= ST_EXACT;
`ifdef FP2INT_ROUND_EN
      r_guard  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op_in;
            r_busy  <= 1'b1;
            r_state <= S_DECODE;
          end
        end

        S_DECODE: begin
          r_sticky <= 1'b0;
`ifdef FP2INT_ROUND_EN
          r_guard  <= 1'b0;
`endif
          r_force  <= 1'b1;
          r_left   <= (w_dist >= 11'sd0);
          r_cnt    <= '0;
          r_state  <= S_WB;
          if (w_zero) begin
            r_sh   <= '0;
            r_stat <= ST_EXACT;
          end else if (w_unf) begin
            r_sh   <= '0;
            r_stat <= ST_UNF;
          end else if (w_small) begin
            r_sh   <= '0;
            r_stat <= ST_INEXACT;
          end else if (w_ovf) begin
            if (w_ovf_exact) begin
              r_sh   <= L_MIN_MAG;
              r_stat <= ST_EXACT;
            end else begin
              r_sh   <= w_sign ? L_MIN_MAG : L_MAX_MAG;
              r_stat <= ST_OVF;
            end
          end else begin
            r_force <= 1'b0;
            r_stat  <= ST_EXACT;
            r_sh    <= {{(OUT_W-21){1'b0}}, w_mag};
            r_cnt   <= w_n[5:0];
            if (w_n != '0) r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (r_left) begin
            r_sh <= r_sh << 1;
          end else begin
            r_sh <= r_sh >> 1;
`ifdef FP2INT_ROUND_EN
            r_guard  <= r_sh[0];
            r_sticky <= r_sticky | r_guard;
`else
            r_sticky <= r_sticky | r_sh[0];
`endif
          end
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) r_state <= S_WB;
        end

        S_WB: begin
          r_data   <= w_res;
          r_status <= r_force ? r_stat : (w_inexact ? ST_INEXACT : ST_EXACT);
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign data_out   = r_data;
  assign status_out = r_status;

endmodule

// File: tb/tb_fp_to_int.sv
// Self-checking bench for fp_to_int: arithmetic reference model plus per-cycle compare.
// Define FP2INT_ROUND_EN for both bench and RTL to exercise rounding.
module tb_fp_to_int;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] op_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  fp_to_int #(.BIAS(511), .OUT_W(32)) dut (
    .clock_100Khz(clk),
    .reset(reset),
    .start(start),
    .op_in(op_in),
    .busy(busy),
    .done(done),
    .data_out(data_out),
    .status_out(status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          when;
    logic [31:0] d;
    logic [3:0]  s;
  } exp_t;
  exp_t q[$];

  int          busy_until = 0;
  logic [31:0] held_d = '0;
  logic [3:0]  held_s = 4'd2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Value = (-1)^s * mag * 2^(e-21), with mag = 1.mant as a 22-bit integer.
  task automatic model(input logic [31:0] f, output logic [31:0] d,
                       output logic [3:0] s, output int n);
    logic   sign;
    int     ex;
    int     e;
    longint mag, qv, rem, half;
    int     sh;
    int     lo;
    sign = f[31];
    ex   = int'(f[30:21]);
    e    = ex - 511;
    mag  = longint'({1'b1, f[20:0]});
    n    = 0;
`ifdef FP2INT_ROUND_EN
    lo = -1;
`else
    lo = 0;
`endif
    if (ex == 0) begin
      d = '0;
      s = (f[20:0] == '0) ? 4'd2 : 4'd1;
    end else if (e < lo) begin
      d = '0;
      s = 4'd3;
    end else if (e > 30) begin
      if (sign && e == 31 && f[20:0] == '0) begin
        d = 32'h8000_0000; s = 4'd2;
      end else begin
        d = sign ? 32'h8000_0000 : 32'h7FFF_FFFF; s = 4'd0;
      end
    end else begin
      if (e >= 21) begin
        n  = e - 21;
        qv = mag * (longint'(1) << n);
        s  = 4'd2;
      end else begin
        sh   = 21 - e;
        n    = sh;
        qv   = mag / (longint'(1) << sh);
        rem  = mag - qv * (longint'(1) << sh);
        s    = (rem != 0) ? 4'd3 : 4'd2;
        half = longint'(1) << (sh - 1);
`ifdef FP2INT_ROUND_EN
        if (rem > half || (rem == half && qv % 2 == 1)) qv = qv + 1;
`else
        if (half < 0) qv = 0;
`endif
      end
      d = 32'(sign ? -qv : qv);
    end
  endtask

  task automatic wait_idle();
    while (cyc < busy_until) @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle.
  task automatic convert(input logic [31:0] op);
    logic [31:0] d;
    logic [3:0]  s;
    int          n;
    exp_t        e;
    start = 1'b1;
    op_in = op;
    @(posedge clk);
    #1;
    model(op, d, s, n);
    e.when = cyc + 2 + n;
    e.d    = d;
    e.s    = s;
    q.push_back(e);
    busy_until = e.when;
    @(negedge clk);
    start = 1'b0;
    op_in = $urandom;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 32'(busy), 32'(cyc < busy_until));
      if (q.size() > 0 && q[0].when == cyc) begin
        chk("done_pulse", 32'(done), 32'd1);
        held_d = q[0].d;
        held_s = q[0].s;
        void'(q.pop_front());
      end else begin
        chk("done_idle", 32'(done), 32'd0);
      end
      chk("data_out", data_out, held_d);
      chk("status_out", 32'(status_out), 32'(held_s));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] op;
    logic [31:0] d;
    logic [3:0]  s;
    int          n;
  } pin_t;

  initial begin
    pin_t        pins[$];
    logic [31:0] pd;
    logic [3:0]  ps;
    int          pn;
    logic [31:0] vec[$];

    reset = 1'b1;
    start = 1'b0;
    op_in = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_status", 32'(status_out), 32'd2);

    pins.push_back('{32'h3FE0_0000, 32'h0000_0001, 4'd2, 21});
    pins.push_back('{32'hC010_0000, 32'hFFFF_FFFD, 4'd2, 20});
    pins.push_back('{32'h4008_0000, 32'h0000_0002, 4'd3, 20});
    pins.push_back('{32'h4300_0000, 32'h0200_0000, 4'd2, 4});
    pins.push_back('{32'h43C0_0000, 32'h7FFF_FFFF, 4'd0, 0});
    pins.push_back('{32'hC3C0_0000, 32'h8000_0000, 4'd2, 0});
    pins.push_back('{32'h0000_0000, 32'h0000_0000, 4'd2, 0});
    pins.push_back('{32'h0000_0001, 32'h0000_0000, 4'd1, 0});
`ifdef FP2INT_ROUND_EN
    pins.push_back('{32'h4018_0000, 32'h0000_0004, 4'd3, 20});
    pins.push_back('{32'h3FC0_0001, 32'h0000_0001, 4'd3, 22});
`else
    pins.push_back('{32'h4018_0000, 32'h0000_0003, 4'd3, 20});
    pins.push_back('{32'h3FC0_0001, 32'h0000_0000, 4'd3, 0});
`endif
    foreach (pins[i]) begin
      model(pins[i].op, pd, ps, pn);
      chk($sformatf("pin_d_%h", pins[i].op), pd, pins[i].d);
      chk($sformatf("pin_s_%h", pins[i].op), 32'(ps), 32'(pins[i].s));
      chk($sformatf("pin_n_%h", pins[i].op), 32'(pn), 32'(pins[i].n));
    end

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    convert(32'h3FE0_0000);
    wait_idle();
    convert(32'hC010_0000);
    wait_idle();
    convert(32'h4008_0000);
    wait_idle();
    convert(32'h4018_0000);
    wait_idle();

    convert(32'h4300_0000);
    start = 1'b1;
    op_in = 32'h3FE0_0000;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    vec = '{32'h43C0_0000, 32'hC3C0_0000, 32'h0000_0000, 32'h8000_0000,
            32'h0000_0001, 32'h3FC0_0000, 32'h3FC0_0001, 32'h3FA0_0000,
            32'h43A0_0000, 32'h43BF_FFFF, 32'hC3A0_0000, 32'hC3C0_0001,
            32'h7FE0_0000, 32'h4140_0000};
    foreach (vec[i]) begin
      convert(vec[i]);
      wait_idle();
    end

    for (int i = 0; i < 20; i++) begin
      logic [9:0] ex;
      ex = 10'(500 + $urandom_range(0, 45));
      convert({1'($urandom), ex, 21'($urandom)});
      wait_idle();
    end

    convert(32'h3FE0_0000);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_data", data_out, 32'd0);
    chk("midrst_status", 32'(status_out), 32'd2);
    q.delete();
    busy_until = 0;
    held_d = '0;
    held_s = 4'd2;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    convert(32'hC010_0000);
    wait_idle();

    repeat (3) @(negedge clk);
    if (q.size() != 0) chk("pending_done", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_to_int.md
Name: fp_to_int

Overview:
- Multi-cycle converter from the team's 32-bit float format to a two's-complement signed integer.
- Float format: sign [31], exponent [30:21] (10 bits, biased), mantissa [20:0] with hidden 1.
- Sits downstream of the FPU adder: it consumes the adder's data_out words and feeds integer consumers such as display and control logic.
- Uses a start/busy/done handshake and reports a status code with the same encoding as the FPU.

Parameters:
- BIAS, 511, exponent bias: value = (-1)^s * 1.mant * 2^(exp-BIAS).
- OUT_W, 32, integer result width. Saturation limits are derived from it.

Ports:
- clock_100Khz  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- op_in  input  32  float operand; latched on an accepted start.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle pulse; data_out and status_out are valid from this cycle.
- data_out  output  OUT_W  signed integer result; held until the next done.
- status_out  output  4  0=OVERFLOW, 1=UNDERFLOW, 2=EXACT, 3=INEXACT.

Behaviour:
- Reset (asynchronous, any state, including mid-conversion):
  - FSM returns to IDLE.
  - busy=0, done=0, data_out=0, status_out=EXACT(2).
  - All internal registers cleared; any in-flight conversion is discarded.
- States: IDLE -> DECODE -> SHIFT -> WRITEBACK -> IDLE.
- IDLE:
  - When start=1, latch op_in and go to DECODE.
  - start while busy=1 is ignored and is not queued.
- DECODE (1 cycle): compute e = exp - BIAS as a signed 11-bit value, with mag = {1, mant} (22 bits). Cases, in priority order:
  - exp==0, mant==0: result 0, EXACT; go to WRITEBACK.
  - exp==0, mant!=0: flushed to 0, UNDERFLOW; go to WRITEBACK.
  - e < 0: result 0, INEXACT; go to WRITEBACK.
  - e > OUT_W-2:
    - Result 2^(OUT_W-1)-1 if sign=0, or -2^(OUT_W-1) if sign=1; status OVERFLOW.
    - Exception: sign=1, e==OUT_W-1, mant==0 is exactly -2^(OUT_W-1), status EXACT.
    - Go to WRITEBACK.
  - Otherwise:
    - Load mag into an OUT_W+1-bit shift register.
    - n = |e-21|; direction is left if e>=21, right if e<21.
    - If n==0, go to WRITEBACK; otherwise go to SHIFT.
- SHIFT:
  - Shift one bit per cycle and decrement the counter; go to WRITEBACK when the count reaches 0.
  - Right shifts OR each bit shifted out into a sticky flag.
- WRITEBACK (1 cycle):
  - Truncate toward zero, then negate (two's complement) if sign=1.
  - status_out = INEXACT if sticky=1, else EXACT (unless DECODE already set OVERFLOW or UNDERFLOW).
  - Register data_out and status_out, pulse done=1, go to IDLE.
- Latency: start is accepted at edge k; done is high in the cycle after edge k+2+n (n=0 for the special cases).
  - A new start may be accepted in the cycle done is high, since the FSM is then in IDLE.
- Widths: left shifts never exceed OUT_W-1 bit positions, because e<=OUT_W-2 guarantees no overflow in the normal path.

Optional Feature:
- Macro FP2INT_ROUND_EN.
- Defined:
  - Round-to-nearest-even replaces truncation. The final right shift captures a guard bit; sticky collects all lower bits.
  - WRITEBACK increments the magnitude when guard=1 and (sticky=1 or lsb=1), before negation.
  - e==-1 is no longer a DECODE special case: it takes the right-shift path with n=22.
  - Status is INEXACT if guard or sticky is set.
- Undefined: truncation toward zero as described above; no guard logic is synthesised.

Test Plan:
- op_in=0x3FE00000 (1.0): data_out=0x00000001, EXACT, done at k+23 (n=21).
- op_in=0xC0100000 (-3.0): data_out=0xFFFFFFFD, EXACT.
- op_in=0x40080000 (2.5): data_out=0x00000002, INEXACT. Same result with FP2INT_ROUND_EN (tie to even); with the macro, 0x40180000 (3.5) gives 4, INEXACT.
- op_in=0x43000000 (2^25): data_out=0x02000000, EXACT, n=4 left shifts; a second start while busy is ignored.
- op_in=0x43C00000: data_out=0x7FFFFFFF, OVERFLOW. op_in=0xC3C00000: data_out=0x80000000, EXACT. op_in=0x00000000: data_out=0, EXACT, done at k+2.
- reset asserted mid-SHIFT: busy, done and data_out go to 0 immediately, status_out=EXACT; the next start converts normally.
